// File: rtl/lsu_exec.sv
// Load/store execution unit: one packet at a time through IDLE -> MEM -> WB.
// Optional macro LSU_MISALIGN_TRAP_EN turns misaligned half/word accesses into exceptions.
module lsu_exec (
    input  logic         clk,
    input  logic         rstn,
    input  logic         i_drive_1,
    output logic         o_free_1,
    input  logic [176:0] i_issue_data_177,
    output logic         o_mem_req_1,
    output logic         o_mem_we_1,
    output logic [31:0]  o_mem_addr_32,
    output logic [3:0]   o_mem_be_4,
    output logic [31:0]  o_mem_wdata_32,
    input  logic         i_mem_ack_1,
    input  logic [31:0]  i_mem_rdata_32,
    output logic         o_drive_wb_1,
    input  logic         i_free_wb_1,
    output logic [4:0]   o_wb_rd_5,
    output logic [3:0]   o_wb_tag_4,
    output logic [31:0]  o_wb_data_32,
    output logic         o_wb_we_1,
    output logic         o_wb_exc_1,
    output logic [1:0]   o_dbg_state_2
);
    // Handshakes: a transfer happens on a rising edge where valid and ready are both high
    // (i_drive_1/o_free_1, o_mem_req_1/i_mem_ack_1, o_drive_wb_1/i_free_wb_1); the
    // valid side holds its payload stable until that edge.
    typedef enum logic [1:0] {IDLE = 2'd0, MEM = 2'd1, WB = 2'd2} state_t;
    state_t state, nextState;

    logic [112:0] instr;
    logic [31:0]  opL, opR, imm, ea;
    logic [2:0]   funct3;
    logic         isStore, isHalf, isWord, legal, misaligned, trap, needMem, accept;
    logic [4:0]   rd;
    logic [3:0]   tag;
    logic [1:0]   alignedOff;
    logic [3:0]   be;
    logic [31:0]  wdata;
    logic         unusedInstr;

    assign instr       = i_issue_data_177[176:64];
    assign opL         = i_issue_data_177[63:32];
    assign opR         = i_issue_data_177[31:0];
    assign imm         = instr[53:22];
    assign funct3      = instr[21:19];
    assign isStore     = instr[18];
    assign rd          = instr[17:13];
    assign tag         = instr[12:9];
    assign unusedInstr = ^{instr[112:54], instr[8:0]};

    assign ea         = opL + imm;
    assign isHalf     = (funct3[1:0] == 2'b01);
    assign isWord     = (funct3[1:0] == 2'b10);
    assign legal      = isStore ? (funct3 inside {3'b000, 3'b001, 3'b010})
                                : (funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    assign misaligned = (isHalf & ea[0]) | (isWord & (ea[1:0] != 2'b00));
`ifdef LSU_MISALIGN_TRAP_EN
    assign trap = legal & misaligned;
`else
    assign trap = 1'b0;
`endif
    assign needMem = legal & ~trap;
    // Without trapping, the low address bits a half/word cannot use are simply dropped.
    assign alignedOff = isWord ? 2'b00 : (isHalf ? {ea[1], 1'b0} : ea[1:0]);
    assign be    = isWord ? 4'b1111 : (isHalf ? (4'b0011 << alignedOff) : (4'b0001 << alignedOff));
    assign wdata = isWord ? opR : (isHalf ? {2{opR[15:0]}} : {4{opR[7:0]}});
    assign accept = i_drive_1 & (state == IDLE);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= nextState;
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (accept) nextState = needMem ? MEM : WB;
            MEM:     if (i_mem_ack_1) nextState = WB;
            WB:      if (i_free_wb_1) nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    logic [31:0] memAddr, memWdata, wbData;
    logic [3:0]  memBe, wbTag;
    logic        memWe, wbWe, wbExc;
    logic [1:0]  rOff;
    logic [2:0]  rFunct3;
    logic [4:0]  wbRd;
    logic [31:0] shifted, loadVal;

    assign shifted = i_mem_rdata_32 >> {rOff, 3'b000};
    always_comb begin
        loadVal = shifted;
        case (rFunct3)
            3'b000:  loadVal = {{24{shifted[7]}}, shifted[7:0]};
            3'b001:  loadVal = {{16{shifted[15]}}, shifted[15:0]};
            3'b100:  loadVal = {24'd0, shifted[7:0]};
            3'b101:  loadVal = {16'd0, shifted[15:0]};
            default: loadVal = shifted;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            memAddr  <= '0;
            memWdata <= '0;
            memBe    <= '0;
            memWe    <= 1'b0;
            rOff     <= '0;
            rFunct3  <= '0;
            wbRd     <= '0;
            wbTag    <= '0;
            wbData   <= '0;
            wbWe     <= 1'b0;
            wbExc    <= 1'b0;
        end else if (accept) begin
            memAddr  <= {ea[31:2], 2'b00};
            memWdata <= wdata;
            memBe    <= be;
            memWe    <= isStore;
            rOff     <= alignedOff;
            rFunct3  <= funct3;
            wbRd     <= rd;
            wbTag    <= tag;
            wbData   <= trap ? ea : 32'd0;
            wbWe     <= 1'b0;
            wbExc    <= ~needMem;
        end else if ((state == MEM) && i_mem_ack_1 && !memWe) begin
            wbData <= loadVal;
            wbWe   <= (wbRd != 5'd0);
        end
    end

    // Outputs are gated by state so everything outside its phase reads as zero.
    assign o_free_1       = (state == IDLE);
    assign o_mem_req_1    = (state == MEM);
    assign o_mem_we_1     = o_mem_req_1 & memWe;
    assign o_mem_addr_32  = o_mem_req_1 ? memAddr  : 32'd0;
    assign o_mem_be_4     = o_mem_req_1 ? memBe    : 4'd0;
    assign o_mem_wdata_32 = o_mem_req_1 ? memWdata : 32'd0;
    assign o_drive_wb_1   = (state == WB);
    assign o_wb_rd_5      = o_drive_wb_1 ? wbRd   : 5'd0;
    assign o_wb_tag_4     = o_drive_wb_1 ? wbTag  : 4'd0;
    assign o_wb_data_32   = o_drive_wb_1 ? wbData : 32'd0;
    assign o_wb_we_1      = o_drive_wb_1 & wbWe;
    assign o_wb_exc_1     = o_drive_wb_1 & wbExc;
    assign o_dbg_state_2  = state;
endmodule

// File: tb/tb_lsu_exec.sv
// Randomised self-checking bench for lsu_exec against a byte-arithmetic reference model.
// Builds with or without LSU_MISALIGN_TRAP_EN; the model follows the same macro.
module tb_lsu_exec;
    logic         clk = 1'b0;
    logic         rstn;
    logic         i_drive_1;
    logic         o_free_1;
    logic [176:0] i_issue_data_177;
    logic         o_mem_req_1, o_mem_we_1;
    logic [31:0]  o_mem_addr_32, o_mem_wdata_32;
    logic [3:0]   o_mem_be_4;
    logic         i_mem_ack_1;
    logic [31:0]  i_mem_rdata_32;
    logic         o_drive_wb_1, i_free_wb_1;
    logic [4:0]   o_wb_rd_5;
    logic [3:0]   o_wb_tag_4;
    logic [31:0]  o_wb_data_32;
    logic         o_wb_we_1, o_wb_exc_1;
    logic [1:0]   o_dbg_state_2;

    int n_checks = 0;
    int n_fails  = 0;
    logic [31:0] exp_q[$];

    lsu_exec dut (
        .clk(clk), .rstn(rstn), .i_drive_1(i_drive_1), .o_free_1(o_free_1),
        .i_issue_data_177(i_issue_data_177),
        .o_mem_req_1(o_mem_req_1), .o_mem_we_1(o_mem_we_1), .o_mem_addr_32(o_mem_addr_32),
        .o_mem_be_4(o_mem_be_4), .o_mem_wdata_32(o_mem_wdata_32),
        .i_mem_ack_1(i_mem_ack_1), .i_mem_rdata_32(i_mem_rdata_32),
        .o_drive_wb_1(o_drive_wb_1), .i_free_wb_1(i_free_wb_1), .o_wb_rd_5(o_wb_rd_5),
        .o_wb_tag_4(o_wb_tag_4), .o_wb_data_32(o_wb_data_32), .o_wb_we_1(o_wb_we_1),
        .o_wb_exc_1(o_wb_exc_1), .o_dbg_state_2(o_dbg_state_2)
    );

    // clock / reset
    always #5 clk = ~clk;

    typedef struct {
        logic        mem_req;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic        we;
        logic        wb_we;
        logic        wb_exc;
        logic [31:0] wb_data;
    } exp_t;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference: plain byte arithmetic on the effective address.
    function automatic exp_t model(input logic [31:0] op_l, input logic [31:0] imm,
                                   input logic [31:0] op_r, input logic [2:0] f3,
                                   input logic st, input logic [4:0] rd,
                                   input logic [31:0] rdata);
        exp_t e;
        logic [31:0] ea, aligned;
        int nb, off;
        logic legal;
        longint v;
        e = '{mem_req: 1'b0, addr: 32'd0, be: 4'd0, wdata: 32'd0, we: 1'b0,
              wb_we: 1'b0, wb_exc: 1'b0, wb_data: 32'd0};
        ea = op_l + imm;
        nb = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        legal = st ? (f3 <= 3'd2) : (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
        if (!legal) begin
            e.wb_exc = 1'b1;
            return e;
        end
`ifdef LSU_MISALIGN_TRAP_EN
        if ((ea % nb) != 0) begin
            e.wb_exc  = 1'b1;
            e.wb_data = ea;
            return e;
        end
`endif
        aligned   = ea - (ea % nb);
        off       = int'(aligned % 4);
        e.mem_req = 1'b1;
        e.addr    = aligned - (aligned % 4);
        e.be      = 4'(((1 << nb) - 1) << off);
        e.we      = st;
        if (nb == 1)      e.wdata = {24'd0, op_r[7:0]} * 32'h0101_0101;
        else if (nb == 2) e.wdata = {16'd0, op_r[15:0]} * 32'h0001_0001;
        else              e.wdata = op_r;
        if (!st) begin
            v = (longint'(rdata) >> (8 * off)) % (longint'(1) << (8 * nb));
            if (f3[2] == 1'b0 && nb < 4 && v >= (longint'(1) << (8 * nb - 1)))
                v = v - (longint'(1) << (8 * nb));
            e.wb_data = v[31:0];
            e.wb_we   = (rd != 5'd0);
        end
        return e;
    endfunction

    function automatic logic [176:0] pack(input logic [31:0] op_l, input logic [31:0] imm,
                                          input logic [31:0] op_r, input logic [2:0] f3,
                                          input logic st, input logic [4:0] rd,
                                          input logic [3:0] tag);
        logic [127:0] r;
        logic [112:0] ins;
        r   = {$urandom, $urandom, $urandom, $urandom};
        ins = r[112:0];
        ins[53:22] = imm;
        ins[21:19] = f3;
        ins[18]    = st;
        ins[17:13] = rd;
        ins[12:9]  = tag;
        return {ins, op_l, op_r};
    endfunction

    // driver: issue one packet, walk it through MEM and WB, checking each cycle
    task automatic run_op(input logic [31:0] op_l, input logic [31:0] imm, input logic [31:0] op_r,
                          input logic [2:0] f3, input logic st, input logic [4:0] rd,
                          input logic [3:0] tag, input logic [31:0] rdata,
                          input int ack_dly, input int free_dly);
        exp_t e;
        logic [31:0] exp_data;
        e = model(op_l, imm, op_r, f3, st, rd, rdata);
        exp_q.push_back(e.wb_data);
        @(negedge clk);
        check("free_idle", 32'(o_free_1), 32'd1);
        i_drive_1 = 1'b1;
        i_issue_data_177 = pack(op_l, imm, op_r, f3, st, rd, tag);
        @(negedge clk);
        i_drive_1 = 1'b0;
        i_issue_data_177 = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        check("mem_req", 32'(o_mem_req_1), 32'(e.mem_req));
        check("free_busy", 32'(o_free_1), 32'd0);
        if (e.mem_req) begin
            for (int i = 0; i <= ack_dly; i++) begin
                check("mem_addr", o_mem_addr_32, e.addr);
                check("mem_be", 32'(o_mem_be_4), 32'(e.be));
                check("mem_we", 32'(o_mem_we_1), 32'(e.we));
                if (e.we) check("mem_wdata", o_mem_wdata_32, e.wdata);
                check("mem_req_hold", 32'(o_mem_req_1), 32'd1);
                check("wb_quiet", 32'(o_drive_wb_1), 32'd0);
                i_free_wb_1 = 1'($urandom);
                if (i == ack_dly) begin
                    i_mem_ack_1 = 1'b1;
                    i_mem_rdata_32 = rdata;
                end else begin
                    i_mem_rdata_32 = $urandom;
                end
                @(negedge clk);
            end
            i_mem_ack_1 = 1'b0;
            i_free_wb_1 = 1'b0;
            i_mem_rdata_32 = $urandom;
        end
        exp_data = exp_q.pop_front();
        for (int i = 0; i <= free_dly; i++) begin
            check("drive_wb", 32'(o_drive_wb_1), 32'd1);
            check("wb_rd", 32'(o_wb_rd_5), 32'(rd));
            check("wb_tag", 32'(o_wb_tag_4), 32'(tag));
            check("wb_data", o_wb_data_32, exp_data);
            check("wb_we", 32'(o_wb_we_1), 32'(e.wb_we));
            check("wb_exc", 32'(o_wb_exc_1), 32'(e.wb_exc));
            check("wb_req_low", 32'(o_mem_req_1), 32'd0);
            check("wb_free_low", 32'(o_free_1), 32'd0);
            i_mem_ack_1 = 1'($urandom);
            if (i == free_dly) i_free_wb_1 = 1'b1;
            @(negedge clk);
        end
        i_free_wb_1 = 1'b0;
        i_mem_ack_1 = 1'b0;
        check("wb_done", 32'(o_drive_wb_1), 32'd0);
        check("free_after", 32'(o_free_1), 32'd1);
    endtask

    initial begin
        rstn = 1'b0;
        i_drive_1 = 1'b0;
        i_issue_data_177 = '0;
        i_mem_ack_1 = 1'b0;
        i_mem_rdata_32 = '0;
        i_free_wb_1 = 1'b0;
        #12;
        check("rst_req", 32'(o_mem_req_1), 32'd0);
        check("rst_drive_wb", 32'(o_drive_wb_1), 32'd0);
        check("rst_addr", o_mem_addr_32, 32'd0);
        check("rst_wb_data", o_wb_data_32, 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        check("rst_free", 32'(o_free_1), 32'd1);

        // directed: LW, LB/LBU lane 3, SH upper half, misaligned LW, long stalls
        run_op(32'h1000, 32'd4, 32'h0, 3'b010, 1'b0, 5'd5, 4'd1, 32'hDEADBEEF, 0, 0);
        run_op(32'h2000, 32'd3, 32'h0, 3'b000, 1'b0, 5'd6, 4'd2, 32'h80112233, 1, 0);
        run_op(32'h2000, 32'd3, 32'h0, 3'b100, 1'b0, 5'd7, 4'd3, 32'h80112233, 0, 1);
        run_op(32'h3000, 32'd2, 32'h0000ABCD, 3'b001, 1'b1, 5'd8, 4'd4, 32'h0, 0, 0);
        run_op(32'h4000, 32'd1, 32'h0, 3'b010, 1'b0, 5'd9, 4'd5, 32'h12345678, 0, 0);
        run_op(32'h5000, 32'd8, 32'h0, 3'b011, 1'b0, 5'd10, 4'd6, 32'h0, 0, 0);
        run_op(32'h6000, 32'd0, 32'h0, 3'b010, 1'b0, 5'd0, 4'd7, 32'hCAFEF00D, 0, 0);
        run_op(32'hFFFF_FFFF, 32'd5, 32'h0, 3'b101, 1'b0, 5'd11, 4'd8, 32'h8765_4321, 10, 5);

        // reset during MEM abandons the access; a late ack must be ignored
        @(negedge clk);
        i_drive_1 = 1'b1;
        i_issue_data_177 = pack(32'h7000, 32'd0, 32'h0, 3'b010, 1'b0, 5'd3, 4'd9);
        @(negedge clk);
        i_drive_1 = 1'b0;
        check("pre_rst_req", 32'(o_mem_req_1), 32'd1);
        #3 rstn = 1'b0;
        #1;
        check("midrst_req", 32'(o_mem_req_1), 32'd0);
        check("midrst_addr", o_mem_addr_32, 32'd0);
        check("midrst_wb", 32'(o_drive_wb_1), 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        check("postrst_free", 32'(o_free_1), 32'd1);
        i_mem_ack_1 = 1'b1;
        i_mem_rdata_32 = 32'h1111_2222;
        @(negedge clk);
        i_mem_ack_1 = 1'b0;
        check("late_ack_wb", 32'(o_drive_wb_1), 32'd0);
        check("late_ack_req", 32'(o_mem_req_1), 32'd0);
        check("late_ack_free", 32'(o_free_1), 32'd1);

        // random traffic
        for (int n = 0; n < 300; n++) begin
            logic [31:0] ol, im;
            ol = $urandom;
            im = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 7)) : $urandom;
            run_op(ol, im, $urandom, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                   5'($urandom_range(0, 31)), 4'($urandom_range(0, 15)), $urandom,
                   $urandom_range(0, 3), $urandom_range(0, 3));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
        $finish;
    end
endmodule

// File: doc/lsu_exec.md
LSU_EXEC -- requirements
Module: lsu_exec

Interface
REQ-001 SHALL have ports: clk  input  1  clock, all state on rising edge.
REQ-002 SHALL have ports: rstn  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have ports: i_drive_1 in 1 issue packet valid; o_free_1 out 1 ready to accept packet.
REQ-004 SHALL have ports: i_issue_data_177 in 177 = {instr[112:0], opL[31:0], opR[31:0]}; instr fields imm=[53:22], funct3=[21:19], is_store=[18], rd=[17:13], tag=[12:9].
REQ-005 SHALL have ports: o_mem_req_1 out 1; o_mem_we_1 out 1; o_mem_addr_32 out 32 word address (bits[1:0]=0); o_mem_be_4 out 4; o_mem_wdata_32 out 32; i_mem_ack_1 in 1; i_mem_rdata_32 in 32 (valid with ack).
REQ-006 SHALL have ports: o_drive_wb_1 out 1; i_free_wb_1 in 1; o_wb_rd_5 out 5; o_wb_tag_4 out 4; o_wb_data_32 out 32; o_wb_we_1 out 1; o_wb_exc_1 out 1.

Function
REQ-007 SHALL implement states IDLE, MEM, WB; o_free_1=1 only in IDLE.
REQ-008 SHALL capture packet on edge where i_drive_1&o_free_1; state->MEM, or->WB if packet takes no memory access (REQ-015/016).
REQ-009 SHALL compute effective address ea = opL + imm modulo 2^32, carry discarded.
REQ-010 SHALL decode loads funct3 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores 000 SB, 001 SH, 010 SW.
REQ-011 SHALL in MEM hold o_mem_req_1=1 and mem address/we/be/wdata stable until i_mem_ack_1 sampled high; then ->WB.
REQ-012 SHALL drive be: byte 0001<<ea[1:0]; half 0011<<{ea[1],0}; word 1111; store wdata = opR byte/half replicated across lanes.
REQ-013 SHALL on load ack register i_mem_rdata_32 lane at ea offset, sign-extend (LB/LH) or zero-extend (LBU/LHU) into o_wb_data_32; stores give o_wb_data_32=0.
REQ-014 SHALL in WB hold o_drive_wb_1=1 and all o_wb_* stable until i_free_wb_1 sampled high; then ->IDLE (o_free_1 high next cycle).
REQ-015 SHALL set o_wb_we_1=1 only for non-excepting loads with rd!=0.
REQ-016 SHALL treat undefined funct3 as illegal: no memory access, WB with exc=1, we=0, data=0.
REQ-017 SHALL ignore i_mem_ack_1 outside MEM and i_free_wb_1 outside WB.
REQ-018 SHALL give minimum occupancy 3 cycles/op: accept edge N, req high cycle N+1, ack at earliest edge N+1, drive_wb cycle N+2.
REQ-019 SHALL copy rd and tag unchanged to o_wb_rd_5/o_wb_tag_4.

Reset
REQ-020 SHALL on rstn low immediately force state IDLE, o_free_1=1 after release, all other outputs 0, including mid-MEM or mid-WB (operation abandoned, no retry).
REQ-021 SHALL require no clock for reset assertion; deassertion synchronous use is upstream's concern.

Configuration
REQ-022 SHALL honour macro LSU_MISALIGN_TRAP_EN.
REQ-023 SHALL with macro defined: misaligned access (half with ea[0]=1, word with ea[1:0]!=0) makes no memory request, goes to WB with exc=1, we=0, o_wb_data_32=ea.
REQ-024 SHALL without macro: misaligned low bits forced to 0 (half ignores ea[0], word ignores ea[1:0]); misalignment never raises exc.

Verification
REQ-025 SHALL cover: LW opL=0x1000 imm=4 rd=5, rdata=0xDEADBEEF -> addr 0x1004, be 1111, wb data 0xDEADBEEF, we=1, exc=0.
REQ-026 SHALL cover: LB ea=0x2003, rdata=0x80112233 -> be 1000, data 0xFFFFFF80; LBU same -> 0x00000080.
REQ-027 SHALL cover: SH opR=0x0000ABCD ea=0x3002 -> we=1, be 1100, wdata 0xABCDABCD, wb we=0, data 0.
REQ-028 SHALL cover: LW ea=0x4001 -> with macro no mem_req, exc=1, data 0x4001; without macro addr 0x4000, exc=0.
REQ-029 SHALL cover: ack held low 10 cycles then i_free_wb_1 low 5 cycles -> req and wb outputs stable throughout, o_free_1=0 until cycle after free_wb.
REQ-030 SHALL cover: rstn pulsed low during MEM -> o_mem_req_1=0 immediately, o_free_1=1 after release, later ack ignored.
